// File: rtl/reg_file_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb_pkg
//  Description : Shared widths, register-address constants and helpers for the
//                register file / scoreboard block.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_file_sb_pkg;

    localparam int LEN_WORD      = 32;
    localparam int LEN_REG_ADDR  = 6;
    localparam int NUM_REGS      = 1 << LEN_REG_ADDR;
    localparam int REG_FLOAT_BIT = 5;

    typedef logic [LEN_REG_ADDR-1:0] reg_addr_t;
    typedef logic [LEN_WORD-1:0]     word_t;

    localparam reg_addr_t REG_ZERO = 6'd0;
    localparam reg_addr_t REG_SP   = 6'd2;
    localparam reg_addr_t REG_HP   = 6'd3;

    // Address 0 (x0) is hard-wired; every other address, including f0, is live.
    function automatic logic is_live(input reg_addr_t addr);
        return addr != REG_ZERO;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : reg_scoreboard
//  Description : Busy-bit tracking for registers with an outstanding write,
//                RAW/WAW hazard detection and the sticky write-back error.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import reg_file_sb_pkg::*;
(
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      iss_valid_i,
    input  reg_addr_t iss_rs1_i,
    input  reg_addr_t iss_rs2_i,
    input  reg_addr_t iss_rd_i,
    input  logic      wb_valid_i,
    input  reg_addr_t wb_addr_i,
    output logic      iss_ready_o,
    output logic      wb_err_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wb_err_q, wb_err_d;
    logic                wb_live;
    logic                iss_fire;

    // A register still counts as free when its write-back lands this cycle.
    function automatic logic eff_busy(input reg_addr_t a);
        return is_live(a) && busy_q[a] && !(wb_live && (wb_addr_i == a));
    endfunction

    // Hazard evaluation: stall on any busy source (RAW) or destination (WAW).
    always_comb begin
        wb_live     = wb_valid_i && is_live(wb_addr_i);
        iss_ready_o = !(eff_busy(iss_rs1_i) || eff_busy(iss_rs2_i) || eff_busy(iss_rd_i));
        iss_fire    = iss_valid_i && iss_ready_o && is_live(iss_rd_i);
    end

    // Next busy vector: clear on write-back, then set on issue so set wins.
    always_comb begin
        busy_d   = busy_q;
        wb_err_d = wb_err_q;
        if (wb_live) begin
            busy_d[wb_addr_i] = 1'b0;
            if (!busy_q[wb_addr_i]) begin
                wb_err_d = 1'b1;
            end
        end
        if (iss_fire) begin
            busy_d[iss_rd_i] = 1'b1;
        end
    end

    // Scoreboard state register; reset discards all outstanding writes.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            busy_q   <= '0;
            wb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err_o = wb_err_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb
//  Description : 32 integer + 32 float register file with same-cycle
//                write-back bypass and an issue-hazard scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter logic [31:0] SP_INIT = 32'h0000_FFF0,
    parameter logic [31:0] HP_INIT = 32'h0000_0000
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  logic      iss_valid_i,
    input  reg_addr_t iss_rs1_i,
    input  reg_addr_t iss_rs2_i,
    input  reg_addr_t iss_rd_i,
    output logic      iss_ready_o,
    output word_t     d_rs1_o,
    output word_t     d_rs2_o,
    input  logic      wb_valid_i,
    input  reg_addr_t wb_addr_i,
    input  word_t     wb_data_i,
    output logic      wb_err_o
);

    word_t regs_q [NUM_REGS];
    logic  wr_en;

    assign wr_en = wb_valid_i && is_live(wb_addr_i);

    // Operand read with write-back bypass; x0 always reads zero.
    function automatic word_t read_port(input reg_addr_t a);
        word_t v;
        v = '0;
        if (is_live(a)) begin
            if (wr_en && (wb_addr_i == a)) begin
                v = wb_data_i;
            end else begin
                v = regs_q[a];
            end
        end
        return v;
    endfunction

    // Combinational operand fetch for both read ports.
    always_comb begin
        d_rs1_o = read_port(iss_rs1_i);
        d_rs2_o = read_port(iss_rs2_i);
    end

    // Storage: reset loads the stack/heap pointers, write-back commits data.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[REG_SP] <= SP_INIT;
            regs_q[REG_HP] <= HP_INIT;
        end else if (wr_en) begin
            regs_q[wb_addr_i] <= wb_data_i;
        end
    end

    reg_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .iss_valid_i (iss_valid_i),
        .iss_rs1_i   (iss_rs1_i),
        .iss_rs2_i   (iss_rs2_i),
        .iss_rd_i    (iss_rd_i),
        .wb_valid_i  (wb_valid_i),
        .wb_addr_i   (wb_addr_i),
        .iss_ready_o (iss_ready_o),
        .wb_err_o    (wb_err_o)
    );

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
# reg_file_sb

Register file and scoreboard that answers the decoder's register-read requests. It holds 32 integer and 32 float registers in one 6-bit address space; address bit 5 selects the float bank. It returns operands for the instruction being issued and tracks registers with an outstanding write. It raises a hazard stall for the issue stage and accepts write-backs from the ALU, FPU, memory and IO units.

## Interface
- SP_INIT, 32'h0000_FFF0, reset value of integer register x2 (stack pointer)
- HP_INIT, 32'h0000_0000, reset value of integer register x3 (heap pointer)

- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-low
- iss_valid  in  1  issue stage presents an instruction this cycle
- iss_rs1  in  6  `LEN_REG_ADDR read address 1 ({float, idx}; 0 = unused)
- iss_rs2  in  6  read address 2
- iss_rd  in  6  destination; 0 = no destination
- iss_ready  out  1  no hazard; instruction issues at this edge when iss_valid
- d_rs1  out  32  `LEN_WORD operand 1
- d_rs2  out  32  operand 2
- wb_valid  in  1  write-back strobe
- wb_addr  in  6  write-back destination
- wb_data  in  32  write-back value
- wb_err  out  1  sticky: write-back to a register not marked busy

## Operation
- Storage: 64 x 32-bit. Address 0 (x0) reads 0 and ignores writes; its busy bit is never set. Address 32 (f0) is an ordinary register.
- Reads are combinational: d_rsN = wb_data when wb_valid and wb_addr == iss_rsN != 0; otherwise 0 when iss_rsN == 0; otherwise the stored value.
- A register is "effectively busy" when its busy bit is set and it is not being written back this cycle.
- Hazard: iss_ready = 0 when any of iss_rs1, iss_rs2 (RAW) or iss_rd (WAW) is nonzero and effectively busy. Otherwise iss_ready = 1. iss_ready does not depend on iss_valid.
- Issue: on an edge with iss_valid & iss_ready & iss_rd != 0, busy[iss_rd] is set.
- Write-back: on an edge with wb_valid & wb_addr != 0, the register is written and busy[wb_addr] is cleared. If busy[wb_addr] was 0, wb_err is set and stays set until reset; the data is still written.
- Simultaneous write-back and issue to the same rd: the write is committed and busy ends at 1, because set has priority over clear.
- wb_valid with wb_addr == 0: no effect at all, including on wb_err.

## Timing
- Reset (asynchronous on rstn low): all registers 0 except x2 = SP_INIT and x3 = HP_INIT. All busy bits 0, wb_err = 0, so iss_ready = 1. Reset during an outstanding write discards all busy state; a late write-back after reset sets wb_err.
- Read latency is 0 cycles, with same-cycle bypass. A write is visible in storage from the following cycle.
- Busy is set at the issue edge and is visible to the next instruction at cycle +1. A dependent instruction stalls until the cycle in which its producer's wb_valid is high, and issues at that edge.
- At most one write-back per cycle; the write-back arbiter lives outside this block.

## Structure
- include.vh holds `LEN_WORD (32) and `LEN_REG_ADDR (6), plus new constants `REG_ZERO (6'd0), `REG_SP (6'd2), `REG_HP (6'd3) and `REG_FLOAT_BIT (5).
- Sub-module reg_scoreboard holds the 64-bit busy vector, the set/clear/priority logic, the hazard evaluation and wb_err. The top level holds storage, bypass and reset initialisation.

## Test plan
- Reset release, then read iss_rs1=2 and iss_rs2=3 -> d_rs1=SP_INIT, d_rs2=HP_INIT, iss_ready=1, wb_err=0.
- Issue rd=5, next cycle iss_rs1=5 -> iss_ready=0. Hold 3 cycles, then wb_valid, wb_addr=5, wb_data=32'hDEAD_BEEF -> same cycle iss_ready=1 and d_rs1=32'hDEAD_BEEF; busy[5]=0 afterwards.
- Write-back wb_addr=0, data 32'h1234 -> x0 still reads 0 and wb_err stays 0. Write-back to idle register 7 -> wb_err=1 and x7 updated.
- Issue rd=33 (f1) and read rs1=1 (x1) -> no stall, confirming bank separation. Issue a second instruction with rd=33 -> iss_ready=0 (WAW).
- Same-cycle wb_addr=9 and issue with rd=9 -> after the edge busy[9]=1 and x9 holds wb_data. A following reader of 9 stalls.
- Set busy on 4 and 6, then pulse rstn low mid-operation -> iss_ready=1 immediately, registers at reset values. A later wb_addr=4 sets wb_err.
